// File: rtl/systolic_pe.sv
// systolic_pe: processing element of an output-stationary systolic
// matrix-multiply array. It multiplies the row operand by the column operand,
// accumulates the product locally, and forwards both operands to its
// neighbours through one register stage each.
//
// Optional build macro: PE_SATURATE_EN
//   undefined (default) - accumulator wraps modulo 2^(2*DATAWIDTH) on overflow
//   defined             - accumulator saturates to all ones on overflow
// The sticky ovf flag is set on overflow in both builds.
module systolic_pe #(
    parameter int DATAWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   acc_clr,
    input  logic [DATAWIDTH-1:0]   a,
    input  logic [DATAWIDTH-1:0]   b,
    output logic [DATAWIDTH-1:0]   a_right,
    output logic [DATAWIDTH-1:0]   b_down,
    output logic [2*DATAWIDTH-1:0] c_out,
    output logic                   ovf
);

    localparam int AW = 2 * DATAWIDTH;

    // Full-width unsigned product; AW bits always hold it, so it never overflows.
    function automatic logic [AW-1:0] mul_full(
        input logic [DATAWIDTH-1:0] x,
        input logic [DATAWIDTH-1:0] y
    );
        logic [AW-1:0] xw;
        logic [AW-1:0] yw;
        xw = {{DATAWIDTH{1'b0}}, x};
        yw = {{DATAWIDTH{1'b0}}, y};
        return xw * yw;
    endfunction

    logic [DATAWIDTH-1:0] a_q;
    logic [DATAWIDTH-1:0] a_d;
    logic [DATAWIDTH-1:0] b_q;
    logic [DATAWIDTH-1:0] b_d;
    logic [AW-1:0]        c_q;
    logic [AW-1:0]        c_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic [AW-1:0]        prod_s;
    logic [AW:0]          sum_s;

    // Product of the current operands and the one-bit-wider accumulation sum;
    // the extra top bit is the carry-out that signals overflow.
    always_comb begin
        prod_s = mul_full(a, b);
        sum_s  = {1'b0, c_q} + {1'b0, prod_s};
    end

    // Next-state selection: hold on stall, restart on clear, otherwise accumulate.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        ovf_d = ovf_q;
        if (en) begin
            a_d = a;
            b_d = b;
            if (acc_clr) begin
                // Restart with the current product so no bubble is inserted.
                c_d   = prod_s;
                ovf_d = 1'b0;
            end else if (sum_s[AW]) begin
                ovf_d = 1'b1;
`ifdef PE_SATURATE_EN
                c_d   = {AW{1'b1}};
`else
                c_d   = sum_s[AW-1:0];
`endif
            end else begin
                c_d   = sum_s[AW-1:0];
            end
        end else begin
            a_d   = a_q;
            b_d   = b_q;
            c_d   = c_q;
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous reset that overrides en and acc_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= {DATAWIDTH{1'b0}};
            b_q   <= {DATAWIDTH{1'b0}};
            c_q   <= {AW{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

    assign a_right = a_q;
    assign b_down  = b_q;
    assign c_out   = c_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe: two PEs chained (PE0 forwarded operands drive PE1).
// A behavioural model with plain integer arithmetic is checked against both
// PEs every cycle, and hand-computed literals pin the model at key points.
module tb_systolic_pe;

    localparam int DW   = 8;
    localparam int AW   = 2 * DW;
    localparam longint MAXV = (64'd1 << AW) - 64'd1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          acc_clr;
    logic [DW-1:0] a_s;
    logic [DW-1:0] b_s;
    logic [DW-1:0] ar0, bd0, ar1, bd1;
    logic [AW-1:0] c0, c1;
    logic          ovf0, ovf1;

    int tests = 0;
    int fails = 0;
    bit check_on = 1'b0;

    // Model state (expected values of both PEs).
    longint m_c0 = 0, m_c1 = 0;
    bit     m_o0 = 1'b0, m_o1 = 1'b0;
    longint m_ar0 = 0, m_bd0 = 0, m_ar1 = 0, m_bd1 = 0;

    systolic_pe #(.DATAWIDTH(DW)) pe0 (
        .clk(clk), .rst(rst), .en(en), .acc_clr(acc_clr),
        .a(a_s), .b(b_s), .a_right(ar0), .b_down(bd0), .c_out(c0), .ovf(ovf0));

    systolic_pe #(.DATAWIDTH(DW)) pe1 (
        .clk(clk), .rst(rst), .en(en), .acc_clr(acc_clr),
        .a(ar0), .b(bd0), .a_right(ar1), .b_down(bd1), .c_out(c1), .ovf(ovf1));

    always #5 clk = ~clk;

    // Accumulator rule in plain arithmetic: returns the new accumulator value.
    function automatic longint acc_next(longint c, longint x, longint y, bit clr);
        longint s;
        if (clr) return x * y;
        s = c + x * y;
        if (s > MAXV) begin
`ifdef PE_SATURATE_EN
            return MAXV;
`else
            return s - (MAXV + 64'd1);
`endif
        end
        return s;
    endfunction

    function automatic bit ovf_next(longint c, bit o, longint x, longint y, bit clr);
        if (clr) return 1'b0;
        if (c + x * y > MAXV) return 1'b1;
        return o;
    endfunction

    // Model update at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_c0 <= 0; m_o0 <= 1'b0; m_ar0 <= 0; m_bd0 <= 0;
            m_c1 <= 0; m_o1 <= 1'b0; m_ar1 <= 0; m_bd1 <= 0;
        end else if (en) begin
            m_c0  <= acc_next(m_c0, longint'(a_s), longint'(b_s), acc_clr);
            m_o0  <= ovf_next(m_c0, m_o0, longint'(a_s), longint'(b_s), acc_clr);
            m_ar0 <= longint'(a_s);
            m_bd0 <= longint'(b_s);
            m_c1  <= acc_next(m_c1, m_ar0, m_bd0, acc_clr);
            m_o1  <= ovf_next(m_c1, m_o1, m_ar0, m_bd0, acc_clr);
            m_ar1 <= m_ar0;
            m_bd1 <= m_bd0;
        end
    end

    task automatic cmp(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both PEs against the model, on the falling edge.
    always @(negedge clk) begin
        if (check_on) begin
            cmp("pe0.c_out",   longint'(c0),   m_c0);
            cmp("pe0.ovf",     longint'(ovf0), longint'(m_o0));
            cmp("pe0.a_right", longint'(ar0),  m_ar0);
            cmp("pe0.b_down",  longint'(bd0),  m_bd0);
            cmp("pe1.c_out",   longint'(c1),   m_c1);
            cmp("pe1.ovf",     longint'(ovf1), longint'(m_o1));
            cmp("pe1.a_right", longint'(ar1),  m_ar1);
            cmp("pe1.b_down",  longint'(bd1),  m_bd1);
        end
    end

    // Apply one set of inputs across one rising edge; returns 2 time units after it.
    task automatic step(input bit r, input bit e, input bit clr, input int x, input int y);
        rst = r; en = e; acc_clr = clr;
        a_s = x[DW-1:0]; b_s = y[DW-1:0];
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; acc_clr = 1'b0; a_s = '0; b_s = '0;
        @(negedge clk);

        // Reset with live inputs and en=1.
        step(1'b1, 1'b1, 1'b0, 7, 3);
        check_on = 1'b1;
        cmp("rst.a_right", longint'(ar0), 0);
        cmp("rst.b_down",  longint'(bd0), 0);
        cmp("rst.c_out",   longint'(c0),  0);
        cmp("rst.ovf",     longint'(ovf0), 0);

        // Accumulate / forward through the chain.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        cmp("acc0.c0", longint'(c0), 0);  cmp("acc0.c1", longint'(c1), 0);
        step(1'b0, 1'b1, 1'b0, 5, 9);
        cmp("acc1.c0", longint'(c0), 45); cmp("acc1.c1", longint'(c1), 0);
        cmp("acc1.ar", longint'(ar0), 5); cmp("acc1.bd", longint'(bd0), 9);
        step(1'b0, 1'b1, 1'b0, 9, 2);
        cmp("acc2.c0", longint'(c0), 63); cmp("acc2.c1", longint'(c1), 45);
        cmp("acc2.ar", longint'(ar0), 9); cmp("acc2.bd", longint'(bd0), 2);
        step(1'b0, 1'b1, 1'b0, 3, 1);
        cmp("acc3.c0", longint'(c0), 66); cmp("acc3.c1", longint'(c1), 63);
        cmp("acc3.ar", longint'(ar0), 3); cmp("acc3.bd", longint'(bd0), 1);
        // Zero operands leave c_out alone but still forward.
        step(1'b0, 1'b1, 1'b0, 0, 7);
        cmp("zero.c0", longint'(c0), 66); cmp("zero.c1", longint'(c1), 66);
        cmp("zero.bd", longint'(bd0), 7);

        // Clear restarts with the current product.
        step(1'b0, 1'b1, 1'b1, 4, 4);
        cmp("clr.c0", longint'(c0), 16);  cmp("clr.c1", longint'(c1), 0);
        step(1'b0, 1'b1, 1'b0, 1, 1);
        cmp("clr2.c0", longint'(c0), 17); cmp("clr2.c1", longint'(c1), 16);

        // Stall: everything holds, acc_clr ignored while en=0.
        step(1'b1, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 5, 9);
        cmp("pre_stall.c0", longint'(c0), 45);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, (i == 1), 9, 9);
            cmp("stall.c0", longint'(c0), 45);
            cmp("stall.ar", longint'(ar0), 5);
            cmp("stall.bd", longint'(bd0), 9);
        end

        // Overflow from 65000.
        step(1'b0, 1'b1, 1'b1, 255, 254);
        cmp("ovf_pre1.c0", longint'(c0), 64770);
        step(1'b0, 1'b1, 1'b0, 23, 10);
        cmp("ovf_pre2.c0", longint'(c0), 65000);
        cmp("ovf_pre2.ovf", longint'(ovf0), 0);
        step(1'b0, 1'b1, 1'b0, 255, 255);
`ifdef PE_SATURATE_EN
        cmp("ovf.c0", longint'(c0), 65535);
`else
        cmp("ovf.c0", longint'(c0), 64489);
`endif
        cmp("ovf.ovf", longint'(ovf0), 1);
        step(1'b0, 1'b1, 1'b0, 255, 255);
`ifdef PE_SATURATE_EN
        cmp("ovf2.c0", longint'(c0), 65535);
`else
        cmp("ovf2.c0", longint'(c0), 63978);
`endif
        cmp("ovf2.ovf", longint'(ovf0), 1);
        // Sticky while stalled and after a small add.
        step(1'b0, 1'b0, 1'b0, 1, 1);
        cmp("ovf_stall.ovf", longint'(ovf0), 1);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        cmp("ovf_sticky.ovf", longint'(ovf0), 1);
        step(1'b0, 1'b1, 1'b1, 2, 3);
        cmp("ovf_clr.c0", longint'(c0), 6);
        cmp("ovf_clr.ovf", longint'(ovf0), 0);

        // Reset mid-accumulation, also with en=0.
        step(1'b0, 1'b1, 1'b0, 8, 8);
        cmp("mid.c0", longint'(c0), 70);
        step(1'b1, 1'b0, 1'b0, 8, 8);
        cmp("mid_rst.c0", longint'(c0), 0);
        cmp("mid_rst.ar", longint'(ar0), 0);
        step(1'b0, 1'b1, 1'b0, 2, 2);
        cmp("post_rst.c0", longint'(c0), 4);

        // A few extra cycles so PE1 drains through the model compare.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 17 * i + 3, 200 - i);

        @(negedge clk);
        check_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
